fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                       |
// | Purpose  : Shared FSM state encoding and default widths for the fetch unit. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fetch_pkg;

   localparam int unsigned c_DEFAULT_AW       = 32;
   localparam int unsigned c_DEFAULT_DW       = 32;
   localparam int unsigned c_DEFAULT_DEPTH    = 2;
   localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned c_PC_STEP          = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_fifo                                                      |
// | Purpose  : Power-of-two prefetch queue with flush; head is read directly.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] head_data,
   output logic         full,
   output logic         empty
);

   localparam int unsigned c_PTR_W = $clog2(DEPTH);
   localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]       r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   // Payload storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_data = r_mem[r_rd_ptr];
   assign full      = (r_count == c_CNT_W'(DEPTH));
   assign empty     = (r_count == '0);

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                      |
// | Purpose  : Single-outstanding instruction fetcher feeding a prefetch queue. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned    AW       = c_DEFAULT_AW,
   parameter int unsigned    DW       = c_DEFAULT_DW,
   parameter int unsigned    DEPTH    = c_DEFAULT_DEPTH,
   parameter logic [AW-1:0]  RESET_PC = AW'(c_DEFAULT_RESET_PC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          redirect_en,
   input  logic [AW-1:0] redirect_pc,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          instr_valid,
   output logic [DW-1:0] instr,
   output logic [AW-1:0] instr_pc,
   input  logic          instr_ready
);

   localparam int unsigned c_W = DW + AW;

   fetch_state_e  r_state;
   fetch_state_e  w_state_nxt;
   logic [AW-1:0] r_fpc;
   logic [AW-1:0] w_fpc_nxt;
   logic [AW-1:0] r_pend_addr;
   logic [AW-1:0] w_pend_nxt;
   logic [AW-1:0] w_redirect_aligned;
   logic          w_grant;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [c_W-1:0] w_head;

   // Fetch addresses are always word aligned, even if the core hands us a byte address.
   assign w_redirect_aligned = {redirect_pc[AW-1:2], 2'b00};

   assign mem_req  = (r_state == S_REQ) && !w_full;
   assign mem_addr = r_fpc;
   assign w_grant  = mem_req && mem_gnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_fpc       <= RESET_PC;
         r_pend_addr <= RESET_PC;
      end else begin
         r_state     <= w_state_nxt;
         r_fpc       <= w_fpc_nxt;
         r_pend_addr <= w_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fpc_nxt   = r_fpc;
      w_pend_nxt  = r_pend_addr;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
            if (redirect_en) begin
               w_fpc_nxt = w_redirect_aligned;
            end
         end
         S_REQ: begin
            if (redirect_en) begin
               w_fpc_nxt   = w_redirect_aligned;
               // A grant coinciding with the redirect still owes us a response to discard.
               w_state_nxt = w_grant ? S_DROP : S_REQ;
            end else if (w_grant) begin
               w_pend_nxt  = r_fpc;
               w_fpc_nxt   = r_fpc + AW'(c_PC_STEP);
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_en) begin
               w_fpc_nxt   = w_redirect_aligned;
               w_state_nxt = mem_rvalid ? S_REQ : S_DROP;
            end else if (mem_rvalid) begin
               w_push      = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_en) begin
               w_fpc_nxt = w_redirect_aligned;
            end
            if (mem_rvalid) begin
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign instr_valid = !w_empty;
   assign w_pop       = instr_valid && instr_ready && !redirect_en;
   assign instr       = w_head[c_W-1 -: DW];
   assign instr_pc    = w_head[AW-1:0];

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (c_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data ({mem_rdata, r_pend_addr}),
      .pop       (w_pop),
      .flush     (redirect_en),
      .head_data (w_head),
      .full      (w_full),
      .empty     (w_empty)
   );

endmodule : fetch_unit
`default_nettype wire
